// File: rtl/lp_pkg.sv
// Shared types and defaults for the LP simplex core.
// Optional Bland's-rule pivoting is selected with LP_PIVOT_COL_BLAND_EN.
package lp_pkg;

  localparam int LP_DATA_W   = 32;
  localparam int LP_MAX_COLS = 64;
  localparam int LP_IDX_W    = $clog2(LP_MAX_COLS);
  localparam int LP_TIMEOUT  = 1024;

  typedef enum logic [2:0] {
    PC_IDLE,
    PC_SCAN,
    PC_DONE,
    PC_WAIT_LOW,
    PC_FAULT
  } pcol_state_t;

  typedef logic signed [LP_DATA_W-1:0] lp_coeff_t;

endpackage

// File: rtl/lp_argmin_acc.sv
// Running signed min/index accumulator with clear and enable.
// Outputs are next-state values so the final beat is visible on the same edge.
module lp_argmin_acc
  import lp_pkg::*;
#(
  parameter int DATA_W = LP_DATA_W,
  parameter int IDX_W  = LP_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
`ifdef LP_PIVOT_COL_BLAND_EN
  input  logic                     bland_i,
`endif
  input  logic signed [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic signed [DATA_W-1:0] best_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic                     found_o
);

  logic signed [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     found_q, found_d;
  logic                     take;

  always_comb begin
`ifdef LP_PIVOT_COL_BLAND_EN
    take = bland_i ? (!found_q && (data_i < 0))
                   : (data_i < best_q);
`else
    take = data_i < best_q;
`endif
  end

  always_comb begin
    best_d  = best_q;
    idx_d   = idx_q;
    found_d = found_q;
    if (clr_i) begin
      best_d  = '0;
      idx_d   = '0;
      found_d = 1'b0;
    end else if (en_i && take) begin
      best_d  = data_i;
      idx_d   = idx_i;
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q  <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      best_q  <= best_d;
      idx_q   <= idx_d;
      found_q <= found_d;
    end
  end

  assign best_o  = best_d;
  assign idx_o   = idx_d;
  assign found_o = found_d;

endmodule

// File: rtl/lp_pivot_col_stage.sv
// Pivot-column stage: picks the entering column from the objective row.
// LP_PIVOT_COL_BLAND_EN selects Bland's rule instead of most-negative.
module lp_pivot_col_stage
  import lp_pkg::*;
#(
  parameter int DATA_W         = LP_DATA_W,
  parameter int MAX_COLS       = LP_MAX_COLS,
  parameter int IDX_W          = $clog2(MAX_COLS),
  parameter int TIMEOUT_CYCLES = LP_TIMEOUT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              pivot_col_valid,
  input  logic [IDX_W:0]    num_cols,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              pivot_col_done,
  output logic              pivot_col_stop,
  output logic [IDX_W-1:0]  pivot_col_idx,
  output logic [DATA_W-1:0] pivot_col_val,
  output logic              optimal
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W:0] MAXC = (IDX_W+1)'(MAX_COLS);
  localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT_CYCLES - 1);

  pcol_state_t state_q, state_d;
  logic [IDX_W:0]  ncols_q, ncols_d;
  logic [IDX_W:0]  count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] val_q;
  logic              opt_q;

  logic [IDX_W:0] cnt_inc;
  logic beat, clr, en, load;
  logic signed [DATA_W-1:0] acc_best;
  logic [IDX_W-1:0]         acc_idx;
  logic                     acc_found;

  // Valid gates ready so a beat on the abort cycle is never taken.
  assign s_tready = (state_q == PC_SCAN) && pivot_col_valid;
  assign beat     = s_tvalid && s_tready;
  assign cnt_inc  = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ncols_d = ncols_q;
    count_d = count_q;
    timer_d = timer_q;
    clr     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      PC_IDLE: begin
        if (pivot_col_valid) begin
          if (num_cols == '0 || num_cols > MAXC) begin
            state_d = PC_FAULT;
          end else begin
            ncols_d = num_cols;
            count_d = '0;
            timer_d = '0;
            clr     = 1'b1;
            state_d = PC_SCAN;
          end
        end
      end
      PC_SCAN: begin
        if (!pivot_col_valid) begin
          state_d = PC_IDLE;
        end else if (beat) begin
          en      = 1'b1;
          timer_d = '0;
          count_d = cnt_inc;
          if (s_tlast) begin
            if (cnt_inc == ncols_q) begin
              state_d = PC_DONE;
              load    = 1'b1;
            end else begin
              state_d = PC_FAULT;
            end
          end else if (cnt_inc == ncols_q) begin
            state_d = PC_FAULT;
          end
        end else if (timer_q == TLIM) begin
          state_d = PC_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PC_DONE: state_d = PC_WAIT_LOW;
      PC_WAIT_LOW: begin
        if (!pivot_col_valid) state_d = PC_IDLE;
      end
      PC_FAULT: state_d = PC_FAULT;
      default:  state_d = PC_IDLE;
    endcase
  end

  lp_argmin_acc #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_acc (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clr_i   (clr),
    .en_i    (en),
`ifdef LP_PIVOT_COL_BLAND_EN
    .bland_i (1'b1),
`endif
    .data_i  ($signed(s_tdata)),
    .idx_i   (count_q[IDX_W-1:0]),
    .best_o  (acc_best),
    .idx_o   (acc_idx),
    .found_o (acc_found)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= PC_IDLE;
      ncols_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      opt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ncols_q <= ncols_d;
      count_q <= count_d;
      timer_q <= timer_d;
      if (load) begin
        idx_q <= acc_idx;
        val_q <= acc_best;
        opt_q <= ~acc_found;
      end
    end
  end

  assign pivot_col_done = (state_q == PC_DONE);
  assign pivot_col_stop = (state_q == PC_FAULT);
  assign pivot_col_idx  = idx_q;
  assign pivot_col_val  = val_q;
  assign optimal        = opt_q;

endmodule

// File: tb/tb_lp_pivot_col_stage.sv
// Directed + random bench for lp_pivot_col_stage with a row-level reference.
module tb_lp_pivot_col_stage;

  localparam int DW = 32;
  localparam int MC = 64;
  localparam int IW = 6;
  localparam int TO = 64;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          pivot_col_valid;
  logic [IW:0]   num_cols;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          pivot_col_done;
  logic          pivot_col_stop;
  logic [IW-1:0] pivot_col_idx;
  logic [DW-1:0] pivot_col_val;
  logic          optimal;

  int n_chk  = 0;
  int n_fail = 0;
  int prev_idx = 0;
  int prev_val = 0;
  bit prev_opt = 1'b0;
  int row[$];

  lp_pivot_col_stage #(
    .DATA_W         (DW),
    .MAX_COLS       (MC),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .pivot_col_valid (pivot_col_valid),
    .num_cols        (num_cols),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tlast         (s_tlast),
    .s_tready        (s_tready),
    .pivot_col_done  (pivot_col_done),
    .pivot_col_stop  (pivot_col_stop),
    .pivot_col_idx   (pivot_col_idx),
    .pivot_col_val   (pivot_col_val),
    .optimal         (optimal)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row-level reference: Dantzig takes the global minimum (first occurrence
  // when negative); Bland takes the first negative entry.
  function automatic void ref_pick(input int d[$], input int n,
                                   output int ri, output int rv,
                                   output bit ro);
    int m;
    ri = 0;
    rv = 0;
    ro = 1'b1;
`ifdef LP_PIVOT_COL_BLAND_EN
    for (int i = 0; i < n; i++) begin
      if (d[i] < 0) begin
        ri = i;
        rv = d[i];
        ro = 1'b0;
        break;
      end
    end
`else
    m = 0;
    for (int i = 0; i < n; i++) if (d[i] < m) m = d[i];
    if (m < 0) begin
      ro = 1'b0;
      rv = m;
      for (int i = 0; i < n; i++) begin
        if (d[i] == m) begin
          ri = i;
          break;
        end
      end
    end
`endif
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, pivot_col_done, 0);
    chk({tag, "_stop"}, pivot_col_stop, 0);
    chk({tag, "_idx"}, pivot_col_idx, 0);
    chk({tag, "_val"}, pivot_col_val, 0);
    chk({tag, "_opt"}, optimal, 0);
    chk({tag, "_rdy"}, s_tready, 0);
  endtask

  task automatic rst_pulse(input string tag);
    pivot_col_valid = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #2 aresetn = 1'b0;
    #1 chk_zero(tag);
    #2 aresetn = 1'b1;
    tick();
    prev_idx = 0;
    prev_val = 0;
    prev_opt = 1'b0;
  endtask

  task automatic run_row(input int d[$], input int ncols,
                         input int last_at, input int stall_max);
    int ei, ev, nb;
    bit eo, ok;
    ok = (last_at == ncols - 1);
    nb = (last_at < ncols - 1) ? last_at + 1 : ncols;
    pivot_col_valid = 1'b1;
    num_cols = (IW+1)'(ncols);
    tick();
    chk("scan_rdy", s_tready, 1);
    for (int i = 0; i < nb; i++) begin
      if (stall_max > 0) repeat ($urandom_range(0, stall_max)) tick();
      s_tvalid = 1'b1;
      s_tdata  = d[i];
      s_tlast  = (i == last_at);
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
    if (ok) begin
      ref_pick(d, ncols, ei, ev, eo);
      chk("done", pivot_col_done, 1);
      chk("idx", pivot_col_idx, ei);
      chk("val", pivot_col_val, ev);
      chk("opt", optimal, eo);
      chk("nostop", pivot_col_stop, 0);
      prev_idx = ei;
      prev_val = ev;
      prev_opt = eo;
      tick();
      chk("done_pulse", pivot_col_done, 0);
      chk("waitlow_rdy", s_tready, 0);
      pivot_col_valid = 1'b0;
      tick();
      chk("idle_rdy", s_tready, 0);
      chk("hold_idx", pivot_col_idx, ei);
    end else begin
      chk("len_stop", pivot_col_stop, 1);
      chk("len_nodone", pivot_col_done, 0);
      pivot_col_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    pivot_col_valid = 1'b0;
    num_cols = '0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    aresetn = 1'b1;
    tick();

    row = '{5, -3, -7, 2};
    run_row(row, 4, 3, 0);
    row = '{1, 0, 4};
    run_row(row, 3, 2, 0);
    row = '{-2, -9, 1};
    run_row(row, 3, 2, 0);
    row = '{-4, -4, 3};
    run_row(row, 3, 2, 0);
    row = '{-7};
    run_row(row, 1, 0, 0);

    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 8);
      row = {};
      for (int i = 0; i < n; i++) row.push_back($urandom_range(0, 40) - 20);
      run_row(row, n, n - 1, 2);
    end

    row = '{1, -2, 3, 4, 5};
    run_row(row, 5, 2, 0);
    pivot_col_valid = 1'b1;
    repeat (3) tick();
    chk("sticky_stop", pivot_col_stop, 1);
    chk("sticky_rdy", s_tready, 0);
    chk("sticky_done", pivot_col_done, 0);
    rst_pulse("fault_rst");

    row = '{3, -1, 2, 2};
    run_row(row, 2, 3, 0);
    rst_pulse("len_rst");

    pivot_col_valid = 1'b1;
    num_cols = '0;
    tick();
    chk("zero_len_stop", pivot_col_stop, 1);
    rst_pulse("zl_rst");

    pivot_col_valid = 1'b1;
    num_cols = (IW+1)'(3);
    tick();
    repeat (TO - 1) tick();
    chk("to_early", pivot_col_stop, 0);
    tick();
    chk("to_stop", pivot_col_stop, 1);
    rst_pulse("to_rst");

    row = '{3, -5, 1};
    run_row(row, 3, 2, 0);
    pivot_col_valid = 1'b1;
    num_cols = (IW+1)'(4);
    tick();
    s_tvalid = 1'b1;
    s_tdata  = -6;
    tick();
    s_tdata  = -20;
    s_tlast  = 1'b1;
    pivot_col_valid = 1'b0;
    #1 chk("abort_rdy", s_tready, 0);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("abort_done", pivot_col_done, 0);
    chk("abort_idx", pivot_col_idx, prev_idx);
    chk("abort_val", pivot_col_val, prev_val);
    chk("abort_opt", optimal, prev_opt);
    chk("abort_stop", pivot_col_stop, 0);
    chk("abort_idle_rdy", s_tready, 0);

    pivot_col_valid = 1'b1;
    num_cols = (IW+1)'(4);
    tick();
    s_tvalid = 1'b1;
    s_tdata  = -5;
    tick();
    s_tdata  = -10;
    rst_pulse("mid_rst");

    row = '{-1, -8, 0, 3};
    run_row(row, 4, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lp_pivot_col_stage.md
Name: lp_pivot_col_stage

Overview:
- Pivot-column compute stage of the LP simplex core; the stage-side responder to the LP control FSM's pivot_col_valid / pivot_col_done / pivot_col_stop handshake.
- Consumes the objective row streamed through the controller's input mux (AXI-Stream style) and selects the entering column: the most negative reduced cost.
- Reports the column index and value, plus an "optimal" flag when no negative coefficient exists.
- Flags protocol or length faults by raising stop.

Parameters:
DATA_W, 32, signed fixed-point coefficient width
MAX_COLS, 64, maximum objective-row length
IDX_W, $clog2(MAX_COLS), column index width
TIMEOUT_CYCLES, 1024, maximum idle cycles between beats while scanning before a fault is raised

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
pivot_col_valid  in  1  level start from controller; held until the cycle after done
num_cols  in  IDX_W+1  expected row length (1..MAX_COLS); sampled on start
s_tdata  in  DATA_W  signed coefficient
s_tvalid  in  1  beat valid
s_tlast  in  1  last coefficient of the row
s_tready  out  1  beat accept
pivot_col_done  out  1  one-cycle completion pulse
pivot_col_stop  out  1  sticky fault flag
pivot_col_idx  out  IDX_W  selected column; valid from done until next start
pivot_col_val  out  DATA_W  coefficient of the selected column
optimal  out  1  no negative coefficient in the row; valid with done

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal best = 0, idx = 0, count = 0, timer = 0.
- States: IDLE, SCAN, DONE, WAIT_LOW, FAULT.
- IDLE:
  - s_tready = 0.
  - If pivot_col_valid = 1 and stop = 0: latch num_cols, best = 0, found = 0, count = 0, timer = 0; go to SCAN.
  - num_cols = 0 or num_cols > MAX_COLS: go to FAULT instead.
- SCAN:
  - s_tready = 1.
  - On each accepted beat (s_tvalid & s_tready), signed compare:
    - if s_tdata < best: best = s_tdata, idx = count, found = 1;
    - count increments; timer clears.
  - Strict less-than, so ties keep the lower index.
- Row end, on a beat with s_tlast:
  - If count+1 == num_cols: go to DONE.
  - Otherwise (early tlast) go to FAULT.
  - A beat with count+1 == num_cols and no tlast also goes to FAULT.
- Timeout: timer counts cycles with no accepted beat; at TIMEOUT_CYCLES go to FAULT.
- Abort: pivot_col_valid falls during SCAN -> return to IDLE, no done, outputs unchanged.
- DONE, one cycle:
  - pivot_col_done = 1.
  - pivot_col_idx = idx, pivot_col_val = best, optimal = ~found.
  - Go to WAIT_LOW.
- Latency: done is asserted exactly 1 cycle after the tlast beat is accepted.
- WAIT_LOW:
  - Stay until pivot_col_valid = 0, then go to IDLE.
  - This prevents a restart from the controller's one-cycle-late valid drop.
- FAULT:
  - pivot_col_stop = 1, s_tready = 0.
  - Only aresetn clears it.
- An asserted aresetn at any point, including mid-scan, returns to reset values immediately.
- Simultaneous events:
  - s_tvalid with tlast on the cycle valid falls: abort wins; the beat is not accepted (s_tready is combinationally gated by valid).
  - Timeout expiring on the same cycle as a beat: the beat wins.

Optional Feature:
- Macro: LP_PIVOT_COL_BLAND_EN.
- Defined: Bland's rule.
  - Select the first negative coefficient (lowest index with s_tdata < 0); later beats never replace it.
  - Scan, length checks and latency are unchanged.
- Undefined: Dantzig most-negative rule, as in Behaviour.

Decomposition:
- Shared package lp_pkg:
  - DATA_W, MAX_COLS, IDX_W defaults;
  - the state enum type pcol_state_t;
  - fixed-point coefficient typedef lp_coeff_t.
- One sub-module is natural: lp_argmin_acc.
  - Registered running min/index accumulator with clear and enable.
  - Takes the rule select under the macro.
  - Reused later by the pivot-row ratio stage.

Test Plan:
1. num_cols=4, stream {5,-3,-7,2}, tlast on 4th -> done pulse 1 cycle later, idx=2, val=-7, optimal=0, stop=0.
2. Stream {1,0,4} with num_cols=3 -> done, optimal=1, idx=0, val=0. With BLAND_EN, {-2,-9,1} -> idx=0, val=-2; without, idx=1, val=-9.
3. Ties {-4,-4,3} -> idx=0. Valid held high for 1 cycle after done -> no second scan; valid low then high -> new scan starts.
4. num_cols=5 but tlast on beat 3 -> stop=1 the next cycle, no done. Stop stays sticky through later valids until aresetn pulses, after which all outputs read 0.
5. Start a scan, then stall s_tvalid for TIMEOUT_CYCLES -> stop=1. Separately, drop pivot_col_valid mid-row -> IDLE, s_tready=0, no done, previous idx retained.
6. Assert aresetn low mid-scan (beat 2 of 4) -> immediate reset values. A subsequent full row {-1,-8,0,3} -> idx=1, val=-8.
